ifmap_window_buffer: RTL and testbench

Circular IFMap scratchpad for the convolution datapath that accepts row-tagged feature-map words, PAR_IN per beat, and replays them as sliding filter windows with programmable filter size and stride. It supersedes the fixed single-lane IFMap buffer and adds multi-lane writes, non-power-of-two depth, row-end handling for stride > 1, and automatic discard of short row tails. It sits between the IFMap loader and the MAC/PE array's IFMap operand port.

---
 rtl/ifmap_window_buffer_if.sv | 28 ++
 rtl/ifmap_window_buffer.sv | 153 +++++++++++++++
 tb/tb_ifmap_window_buffer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifmap_window_buffer_if.sv
// Write-side and window-read-side handshake bundle for ifmap_window_buffer.
// master: IFMap loader / PE operand consumer; slave: the window buffer.
// Ports: wen/wdata/ready (row-tagged writes), win_ren/win_avail and the registered read outputs.
interface ifmap_window_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PAR_IN     = 1
);
  logic                               wen;
  logic [PAR_IN*(DATA_WIDTH+2)-1:0]   wdata;
  logic                               ready;
  logic                               win_ren;
  logic                               win_avail;
  logic [DATA_WIDTH-1:0]              rdata;
  logic                               rdata_valid;
  logic                               row_first;
  logic                               win_last;
  logic                               row_last;

  modport master (
    output wen, wdata, win_ren,
    input  ready, win_avail, rdata, rdata_valid, row_first, win_last, row_last
  );

  modport slave (
    input  wen, wdata, win_ren,
    output ready, win_avail, rdata, rdata_valid, row_first, win_last, row_last
  );
endinterface

// File: rtl/ifmap_window_buffer.sv
// Circular IFMap scratchpad replaying row-tagged words as sliding windows (size F, stride S).
// Latency: one cycle from an accepted win_ren to rdata/rdata_valid and the window flags.
// Backpressure: ready drops when fewer than PAR_IN slots are free; freed space is visible next cycle.
// Ports: clk, rst (sync, active-high), clr (flush keeping drop_cnt), filter_size/stride config,
//        bus (wen/wdata/ready write side, win_ren/win_avail/rdata/... read side), count, drop_cnt.
module ifmap_window_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int PAR_IN     = 1,
  parameter int SIZE_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [SIZE_WIDTH-1:0] filter_size,
  input  logic [SIZE_WIDTH-1:0] stride,
  ifmap_window_buffer_if.slave  bus,
  output logic [ADDR_WIDTH:0]   count,
  output logic [7:0]            drop_cnt
);

  localparam int WW   = DATA_WIDTH + 2;
  localparam int MAXF = (1 << SIZE_WIDTH) - 1;

  typedef logic [WW-1:0]         word_t;
  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;

  localparam logic [ADDR_WIDTH+1:0] DEPTH_X = (ADDR_WIDTH+2)'(DEPTH);
  localparam cnt_t                  PAR_W   = cnt_t'(PAR_IN);

  // a < DEPTH and b <= DEPTH, so a single conditional subtract wraps correctly
  // for any DEPTH, power of two or not.
  function automatic ptr_t wrap_add(input ptr_t a, input cnt_t b);
    logic [ADDR_WIDTH+1:0] s;
    s = {2'b00, a} + {1'b0, b};
    if (s >= DEPTH_X) s = s - DEPTH_X;
    return s[ADDR_WIDTH-1:0];
  endfunction

  word_t                 mem [DEPTH];
  ptr_t                  wr_ptr;
  ptr_t                  base;
  logic [SIZE_WIDTH-1:0] elem_cnt;

  logic [SIZE_WIDTH-1:0] f_eff;
  logic [SIZE_WIDTH-1:0] s_eff;
  cnt_t                  f_w;
  cnt_t                  s_w;
  cnt_t                  pop;
  cnt_t                  trim_len;
  logic                  trim;
  logic                  trim_fire;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  last_elem;
  logic                  tail_end;
  logic                  head_start;
  logic                  ready_i;
  logic                  win_avail_i;
  word_t                 cur_word;

  always_comb begin
    f_eff = (filter_size == '0) ? SIZE_WIDTH'(1) : filter_size;
    s_eff = (stride == '0) ? SIZE_WIDTH'(1) : stride;
    if (s_eff > f_eff) s_eff = f_eff;
  end

  assign f_w = cnt_t'(f_eff);
  assign s_w = cnt_t'(s_eff);

  // A row end inside the first F-1 slots means the row tail is too short to
  // ever fill a window. Scan high-to-low so the lowest such offset wins.
  always_comb begin
    trim     = 1'b0;
    trim_len = '0;
    for (int k = MAXF - 2; k >= 0; k--) begin
      if ((k + 1) < int'(f_eff) && k < int'(count) &&
          mem[wrap_add(base, cnt_t'(k))][DATA_WIDTH]) begin
        trim     = 1'b1;
        trim_len = cnt_t'(k + 1);
      end
    end
  end

  assign ready_i     = (int'(count) + PAR_IN) <= DEPTH;
  assign win_avail_i = (count >= f_w) && !trim;
  assign bus.ready     = ready_i;
  assign bus.win_avail = win_avail_i;

  assign rd_fire    = bus.win_ren && win_avail_i;
  assign wr_fire    = bus.wen && ready_i;
  assign trim_fire  = trim && (elem_cnt == '0);
  assign last_elem  = (cnt_t'(elem_cnt) == (f_w - cnt_t'(1)));
  assign cur_word   = mem[wrap_add(base, cnt_t'(elem_cnt))];
  assign head_start = mem[base][DATA_WIDTH+1];
  assign tail_end   = mem[wrap_add(base, f_w - cnt_t'(1))][DATA_WIDTH];

  // A window ending on the row-end word consumes the whole row tail;
  // otherwise it slides by the stride.
  always_comb begin
    pop = '0;
    if (trim_fire)
      pop = trim_len;
    else if (rd_fire && last_elem)
      pop = tail_end ? f_w : s_w;
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && !clr && wr_fire) begin
      for (int i = 0; i < PAR_IN; i++)
        mem[wrap_add(wr_ptr, cnt_t'(i))] <= bus.wdata[i*WW +: WW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr          <= '0;
      base            <= '0;
      count           <= '0;
      elem_cnt        <= '0;
      bus.rdata       <= '0;
      bus.rdata_valid <= 1'b0;
      bus.row_first   <= 1'b0;
      bus.win_last    <= 1'b0;
      bus.row_last    <= 1'b0;
      if (rst) drop_cnt <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wrap_add(wr_ptr, PAR_W);
      base  <= wrap_add(base, pop);
      // The write slots are free in this cycle, so adding before subtracting
      // never exceeds DEPTH.
      count <= count + (wr_fire ? PAR_W : cnt_t'(0)) - pop;
      if (trim_fire && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

      bus.rdata_valid <= rd_fire;
      if (rd_fire) begin
        bus.rdata     <= cur_word[DATA_WIDTH-1:0];
        bus.row_first <= head_start;
        bus.win_last  <= last_elem;
        bus.row_last  <= tail_end;
        elem_cnt      <= last_elem ? '0 : elem_cnt + SIZE_WIDTH'(1);
      end else begin
        bus.row_first <= 1'b0;
        bus.win_last  <= 1'b0;
        bus.row_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifmap_window_buffer.sv
module tb_ifmap_window_buffer;
  localparam int DW = 16;
  localparam int D  = 10;
  localparam int AW = 4;
  localparam int SW = 3;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst1, clr1, rst2, clr2;
  logic [SW-1:0] fs1, st1, fs2, st2;
  logic [AW:0]   count1, count2;
  logic [7:0]    drop1, drop2;

  ifmap_window_buffer_if #(.DATA_WIDTH(DW), .PAR_IN(1)) bus1 ();
  ifmap_window_buffer_if #(.DATA_WIDTH(DW), .PAR_IN(2)) bus2 ();

  ifmap_window_buffer #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW), .PAR_IN(1), .SIZE_WIDTH(SW)) u_dut1 (
    .clk(clk), .rst(rst1), .clr(clr1), .filter_size(fs1), .stride(st1),
    .bus(bus1), .count(count1), .drop_cnt(drop1));

  ifmap_window_buffer #(.DATA_WIDTH(DW), .DEPTH(D), .ADDR_WIDTH(AW), .PAR_IN(2), .SIZE_WIDTH(SW)) u_dut2 (
    .clk(clk), .rst(rst2), .clr(clr2), .filter_size(fs2), .stride(st2),
    .bus(bus2), .count(count2), .drop_cnt(drop2));

  typedef struct packed {
    logic [15:0] d;
    logic        f;
    logic        wl;
    logic        rl;
  } out_t;

  typedef struct {
    logic        wen;
    logic [17:0] wd;
    logic        ren;
    logic        e_vld;
    logic [15:0] e_dat;
    logic        e_f;
    logic        e_wl;
    logic        e_rl;
    int          e_cnt;
    int          e_drop;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          exp_drop;
  int          mdl_drops;
  logic [17:0] mdl_in[$];
  out_t        exp_q[$];
  out_t        got[$];
  vec_t        tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] w(input logic [15:0] d, input logic s, input logic e);
    return {s, e, d};
  endfunction

  function automatic vec_t vec(input logic wen, input logic [17:0] wd, input logic ren,
                               input logic vld, input logic [15:0] dat, input logic f,
                               input logic wl, input logic rl, input int cnt, input int drop);
    vec_t v;
    v.wen = wen; v.wd = wd; v.ren = ren; v.e_vld = vld; v.e_dat = dat;
    v.e_f = f; v.e_wl = wl; v.e_rl = rl; v.e_cnt = cnt; v.e_drop = drop;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue-based reference: drop short row tails, emit full windows, slide by S
  // or by F when the window ends on the row-end word.
  task automatic run_model(input int f, input int s);
    int   fe, se, cut, n;
    bit   done;
    out_t o;
    fe = (f == 0) ? 1 : f;
    se = (s == 0) ? 1 : s;
    if (se > fe) se = fe;
    exp_q.delete();
    mdl_drops = 0;
    done = 1'b0;
    while (!done) begin
      cut = -1;
      for (int k = 0; k < fe - 1 && k < mdl_in.size(); k++)
        if (cut < 0 && mdl_in[k][16]) cut = k;
      if (cut >= 0) begin
        for (int k = 0; k <= cut; k++) void'(mdl_in.pop_front());
        mdl_drops++;
      end else if (mdl_in.size() < fe) begin
        done = 1'b1;
      end else begin
        for (int k = 0; k < fe; k++) begin
          o.d  = mdl_in[k][15:0];
          o.f  = mdl_in[0][17];
          o.wl = (k == fe - 1);
          o.rl = mdl_in[fe-1][16];
          exp_q.push_back(o);
        end
        n = mdl_in[fe-1][16] ? fe : se;
        for (int k = 0; k < n; k++) void'(mdl_in.pop_front());
      end
    end
  endtask

  function automatic out_t cap1();
    out_t o;
    o.d = bus1.rdata; o.f = bus1.row_first; o.wl = bus1.win_last; o.rl = bus1.row_last;
    return o;
  endfunction

  initial begin
    int          t1v[10];
    logic [17:0] wd;
    logic [17:0] wr_s[25];
    out_t        e;
    int          first_c, last_c, idx;
    logic        acc;

    rst1 = 1'b1; clr1 = 1'b0; fs1 = '0; st1 = '0;
    rst2 = 1'b1; clr2 = 1'b0; fs2 = '0; st2 = '0;
    bus1.wen = 1'b0; bus1.wdata = '0; bus1.win_ren = 1'b0;
    bus2.wen = 1'b0; bus2.wdata = '0; bus2.win_ren = 1'b0;
    tick(); tick();
    rst1 = 1'b0;
    tick();

    // Reset state
    chk("rst ready", bus1.ready, 1);
    chk("rst win_avail", bus1.win_avail, 0);
    chk("rst rdata", bus1.rdata, 0);
    chk("rst rdata_valid", bus1.rdata_valid, 0);
    chk("rst row_first", bus1.row_first, 0);
    chk("rst win_last", bus1.win_last, 0);
    chk("rst row_last", bus1.row_last, 0);
    chk("rst count", count1, 0);
    chk("rst drop_cnt", drop1, 0);

    // F=6, S=1 over a 10-word row filling the buffer exactly
    t1v = '{0, 0, -1, 2, -1, -2, 2, 0, 1, 1};
    fs1 = 3'd6; st1 = 3'd1;
    mdl_in.delete();
    for (int i = 0; i < 10; i++) begin
      wd = w(16'(t1v[i]), i == 0, i == 9);
      mdl_in.push_back(wd);
      bus1.wen = 1'b1; bus1.wdata = wd;
      tick();
    end
    bus1.wen = 1'b0;
    chk("t1 full count", count1, 10);
    chk("t1 full ready", bus1.ready, 0);
    chk("t1 win_avail", bus1.win_avail, 1);
    run_model(6, 1);
    got.delete(); first_c = -1; last_c = -1;
    bus1.win_ren = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus1.rdata_valid) begin
        got.push_back(cap1());
        if (first_c < 0) first_c = c;
        last_c = c;
      end
    end
    bus1.win_ren = 1'b0;
    chk("t1 n_elems", got.size(), 30);
    chk("t1 back_to_back", last_c - first_c, 29);
    for (int j = 0; j < exp_q.size(); j++)
      if (j < got.size()) chk($sformatf("t1 el%0d", j), got[j], exp_q[j]);
    if (got.size() == 30) begin
      e = '{d: 16'h0000, f: 1'b1, wl: 1'b0, rl: 1'b0};
      chk("t1 w0 first", got[0], e);
      e = '{d: 16'hFFFE, f: 1'b1, wl: 1'b1, rl: 1'b0};
      chk("t1 w0 last", got[5], e);
      e = '{d: 16'h0001, f: 1'b0, wl: 1'b1, rl: 1'b1};
      chk("t1 w4 last", got[29], e);
    end
    chk("t1 end count", count1, 0);
    chk("t1 end drop", drop1, 0);

    // F=3, S=3 over an 8-word row: two windows then the 2-word tail is trimmed
    fs1 = 3'd3; st1 = 3'd3;
    for (int i = 0; i < 8; i++)
      tbl[i] = vec(1'b1, w(16'(i + 1), i == 0, i == 7), 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, i + 1, 0);
    tbl[8]  = vec(1'b0, 18'd0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b0, 1'b0, 8, 0);
    tbl[9]  = vec(1'b0, 18'd0, 1'b1, 1'b1, 16'd2, 1'b1, 1'b0, 1'b0, 8, 0);
    tbl[10] = vec(1'b0, 18'd0, 1'b1, 1'b1, 16'd3, 1'b1, 1'b1, 1'b0, 5, 0);
    tbl[11] = vec(1'b0, 18'd0, 1'b1, 1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 5, 0);
    tbl[12] = vec(1'b0, 18'd0, 1'b1, 1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 5, 0);
    tbl[13] = vec(1'b0, 18'd0, 1'b1, 1'b1, 16'd6, 1'b0, 1'b1, 1'b0, 2, 0);
    tbl[14] = vec(1'b0, 18'd0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 0, 1);
    tbl[15] = vec(1'b0, 18'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      bus1.wen = tbl[i].wen; bus1.wdata = tbl[i].wd; bus1.win_ren = tbl[i].ren;
      tick();
      chk($sformatf("t2[%0d] valid", i), bus1.rdata_valid, tbl[i].e_vld);
      if (tbl[i].e_vld) begin
        chk($sformatf("t2[%0d] rdata", i), bus1.rdata, tbl[i].e_dat);
        chk($sformatf("t2[%0d] row_first", i), bus1.row_first, tbl[i].e_f);
        chk($sformatf("t2[%0d] win_last", i), bus1.win_last, tbl[i].e_wl);
        chk($sformatf("t2[%0d] row_last", i), bus1.row_last, tbl[i].e_rl);
      end
      chk($sformatf("t2[%0d] count", i), count1, tbl[i].e_cnt);
      chk($sformatf("t2[%0d] drop", i), drop1, tbl[i].e_drop);
    end
    bus1.wen = 1'b0; bus1.win_ren = 1'b0;
    exp_drop = 1;

    // Wrap-around: 25-word row streamed while reading, F=4, S=2
    fs1 = 3'd4; st1 = 3'd2;
    mdl_in.delete();
    for (int i = 0; i < 25; i++) begin
      wr_s[i] = w(16'(100 + i), i == 0, i == 24);
      mdl_in.push_back(wr_s[i]);
    end
    run_model(4, 2);
    got.delete(); idx = 0;
    bus1.win_ren = 1'b1;
    for (int c = 0; c < 200; c++) begin
      acc = (idx < 25) && bus1.ready;
      bus1.wen = acc;
      if (idx < 25) bus1.wdata = wr_s[idx];
      tick();
      if (acc) idx++;
      if (bus1.rdata_valid) got.push_back(cap1());
    end
    bus1.wen = 1'b0; bus1.win_ren = 1'b0;
    chk("wrap words_written", idx, 25);
    chk("wrap n_elems", got.size(), exp_q.size());
    for (int j = 0; j < exp_q.size(); j++)
      if (j < got.size()) chk($sformatf("wrap el%0d", j), got[j], exp_q[j]);
    exp_drop = exp_drop + mdl_drops;
    chk("wrap count", count1, 0);
    chk("wrap drop", drop1, exp_drop);

    // clr at elem_cnt=3 of F=6, then the same with rst
    for (int pass = 0; pass < 2; pass++) begin
      fs1 = 3'd6; st1 = 3'd1;
      for (int i = 0; i < 6; i++) begin
        bus1.wen = 1'b1; bus1.wdata = w(16'(200 + i), 1'b0, 1'b0);
        tick();
      end
      bus1.wen = 1'b0;
      bus1.win_ren = 1'b1;
      for (int j = 0; j < 3; j++) begin
        tick();
        chk($sformatf("flush%0d el%0d", pass, j), bus1.rdata, 200 + j);
      end
      if (pass == 0) clr1 = 1'b1; else rst1 = 1'b1;
      tick();
      clr1 = 1'b0; rst1 = 1'b0;
      if (pass == 1) exp_drop = 0;
      chk($sformatf("flush%0d valid", pass), bus1.rdata_valid, 0);
      chk($sformatf("flush%0d count", pass), count1, 0);
      chk($sformatf("flush%0d win_avail", pass), bus1.win_avail, 0);
      chk($sformatf("flush%0d ready", pass), bus1.ready, 1);
      chk($sformatf("flush%0d drop", pass), drop1, exp_drop);
      tick();
      chk($sformatf("flush%0d valid2", pass), bus1.rdata_valid, 0);
      bus1.win_ren = 1'b0;
    end

    // F=0, S=0: every word is its own window
    fs1 = 3'd0; st1 = 3'd0;
    for (int i = 0; i < 3; i++) begin
      bus1.wen = 1'b1; bus1.wdata = w(16'(16'h31 + i), i == 0, i == 2);
      tick();
    end
    bus1.wen = 1'b0;
    bus1.win_ren = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      e = '{d: 16'(16'h31 + j), f: (j == 0), wl: 1'b1, rl: (j == 2)};
      chk($sformatf("f0 el%0d", j), cap1(), e);
      chk($sformatf("f0 valid%0d", j), bus1.rdata_valid, 1);
      chk($sformatf("f0 count%0d", j), count1, 2 - j);
    end
    tick();
    chk("f0 idle valid", bus1.rdata_valid, 0);
    bus1.win_ren = 1'b0;

    // PAR_IN=2: fill, overflow beat, retire concurrent with a rejected write
    fs2 = 3'd2; st2 = 3'd2;
    tick();
    rst2 = 1'b0;
    tick();
    for (int b = 0; b < 6; b++) begin
      chk($sformatf("p2 ready b%0d", b), bus2.ready, (b < 5));
      bus2.wen = 1'b1;
      bus2.wdata = {w(16'(2*b + 17), 1'b0, 1'b0), w(16'(2*b + 16), 1'b0, 1'b0)};
      tick();
      chk($sformatf("p2 count b%0d", b), count2, (b < 5) ? 2*(b + 1) : 10);
    end
    bus2.wen = 1'b0;
    chk("p2 full ready", bus2.ready, 0);
    bus2.win_ren = 1'b1;
    tick();
    chk("p2 A rdata", bus2.rdata, 16);
    chk("p2 A valid", bus2.rdata_valid, 1);
    bus2.wen = 1'b1;
    bus2.wdata = {w(16'hBB, 1'b0, 1'b0), w(16'hAA, 1'b0, 1'b0)};
    tick();
    bus2.wen = 1'b0;
    chk("p2 B rdata", bus2.rdata, 17);
    chk("p2 B win_last", bus2.win_last, 1);
    chk("p2 B count", count2, 8);
    chk("p2 B ready", bus2.ready, 1);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk($sformatf("p2 drain el%0d", j), bus2.rdata, 18 + j);
    end
    bus2.win_ren = 1'b0;
    chk("p2 drain count", count2, 0);
    chk("p2 drop", drop2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
